sys_bus_router: RTL and testbench

Address-decoding router between the single system-bus master (PS-AXI bridge, or the bus model in benches) and up to SLV_N register-bank slaves. It registers each write/read strobe, forwards it to the slave selected by the address region field and waits for that slave's acknowledge. It then returns one registered ack/err/rdata response to the master. A timeout converts a silent slave into an error response, so the master never hangs.

---
 rtl/sys_bus_pkg.sv | 28 ++
 rtl/sys_bus_tmo.sv | 40 ++++
 rtl/sys_bus_router.sv | 151 +++++++++++++++
 tb/tb_sys_bus_router.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types and defaults for the system-bus router: FSM encoding, slave-array defaults, clog2 helper.
package sys_bus_pkg;

   localparam int unsigned SLV_N_DEF  = 8;
   localparam int unsigned SLV_AW_DEF = 20;

   localparam logic [1:0] ENC_IDLE  = 2'd0;
   localparam logic [1:0] ENC_ISSUE = 2'd1;
   localparam logic [1:0] ENC_WAIT  = 2'd2;
   localparam logic [1:0] ENC_RESP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ENC_IDLE,
      ST_ISSUE = ENC_ISSUE,
      ST_WAIT  = ENC_WAIT,
      ST_RESP  = ENC_RESP
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sys_bus_tmo.sv
// Clearable WAIT-cycle counter; exp_o flags the WAIT cycle on whose edge the count reaches TMO_CYC.
module sys_bus_tmo #(
   parameter int unsigned TMO_CYC = 255
)(
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);

   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 32'd1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // next count: cleared on issue, saturating increment while waiting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 16'd0;
      end else if (en_i && (cnt_q != TMO_LAST)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign exp_o = en_i && (cnt_q == TMO_LAST);

endmodule

// File: rtl/sys_bus_router.sv
// Routes single system-bus strobes to the slave selected by the address region, returns one registered response.
// Optional macro SYS_BUS_ROUTER_TMO_EN: a silent slave is answered with err after TMO_CYC WAIT cycles.
module sys_bus_router
   import sys_bus_pkg::*;
#(
   parameter int unsigned AXI_DW  = 32,
   parameter int unsigned AXI_AW  = 32,
   parameter int unsigned AXI_SW  = AXI_DW >> 3,
   parameter int unsigned SLV_N   = SLV_N_DEF,
   parameter int unsigned SLV_AW  = SLV_AW_DEF,
   parameter int unsigned TMO_CYC = 255
)(
   input  logic                     sys_clk_i,
   input  logic                     sys_rstn_i,
   input  logic [AXI_AW-1:0]        sys_addr_i,
   input  logic [AXI_DW-1:0]        sys_wdata_i,
   input  logic [AXI_SW-1:0]        sys_sel_i,
   input  logic                     sys_wen_i,
   input  logic                     sys_ren_i,
   output logic [AXI_DW-1:0]        sys_rdata_o,
   output logic                     sys_err_o,
   output logic                     sys_ack_o,
   output logic [SLV_AW-1:0]        slv_addr_o,
   output logic [AXI_DW-1:0]        slv_wdata_o,
   output logic [AXI_SW-1:0]        slv_sel_o,
   output logic [SLV_N-1:0]         slv_wen_o,
   output logic [SLV_N-1:0]         slv_ren_o,
   input  logic [SLV_N*AXI_DW-1:0]  slv_rdata_i,
   input  logic [SLV_N-1:0]         slv_err_i,
   input  logic [SLV_N-1:0]         slv_ack_i
);

   localparam int unsigned RW = clog2(SLV_N);

   state_e              state_q;
   logic                wr_q;
   logic [RW-1:0]       idx_q;
   logic [AXI_DW-1:0]   rsp_data_q;
   logic                rsp_err_q;
   logic [AXI_DW-1:0]   sys_rdata_q;
   logic                sys_err_q;
   logic                sys_ack_q;
   logic [SLV_AW-1:0]   slv_addr_q;
   logic [AXI_DW-1:0]   slv_wdata_q;
   logic [AXI_SW-1:0]   slv_sel_q;
   logic [SLV_N-1:0]    slv_wen_q;
   logic [SLV_N-1:0]    slv_ren_q;

   logic [RW-1:0]       region_s;
   logic [SLV_N-1:0]    onehot_s;
   logic                sel_ack_s;
   logic                sel_err_s;
   logic [AXI_DW-1:0]   sel_rdata_s;
   logic                tmo_exp_s;
   logic                unused_s;

   assign region_s    = sys_addr_i[SLV_AW +: RW];
   assign onehot_s    = {{(SLV_N-1){1'b0}}, 1'b1} << region_s;
   assign sel_ack_s   = slv_ack_i[idx_q];
   assign sel_err_s   = slv_err_i[idx_q];
   assign sel_rdata_s = slv_rdata_i[32'(idx_q) * AXI_DW +: AXI_DW];

`ifdef SYS_BUS_ROUTER_TMO_EN
   sys_bus_tmo #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo (
      .clk_i  (sys_clk_i),
      .rstn_i (sys_rstn_i),
      .clr_i  (state_q == ST_ISSUE),
      .en_i   (state_q == ST_WAIT),
      .exp_o  (tmo_exp_s)
   );
   assign unused_s = ^sys_addr_i[AXI_AW-1:SLV_AW+RW];
`else
   assign tmo_exp_s = 1'b0;
   assign unused_s  = ^{sys_addr_i[AXI_AW-1:SLV_AW+RW], 16'(TMO_CYC)};
`endif

   // transaction FSM with all master- and slave-facing outputs registered
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         idx_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         sys_rdata_q <= '0;
         sys_err_q   <= 1'b0;
         sys_ack_q   <= 1'b0;
         slv_addr_q  <= '0;
         slv_wdata_q <= '0;
         slv_sel_q   <= '0;
         slv_wen_q   <= '0;
         slv_ren_q   <= '0;
      end else begin
         slv_wen_q <= '0;
         slv_ren_q <= '0;
         sys_ack_q <= 1'b0;
         sys_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sys_wen_i || sys_ren_i) begin
                  wr_q        <= sys_wen_i;
                  idx_q       <= region_s;
                  slv_addr_q  <= sys_addr_i[SLV_AW-1:0];
                  slv_wdata_q <= sys_wdata_i;
                  slv_sel_q   <= sys_sel_i;
                  // write wins when both strobes arrive together
                  slv_wen_q   <= sys_wen_i ? onehot_s : '0;
                  slv_ren_q   <= sys_wen_i ? '0 : onehot_s;
                  state_q     <= ST_ISSUE;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (sel_ack_s) begin
                  rsp_data_q <= wr_q ? '0 : sel_rdata_s;
                  rsp_err_q  <= sel_err_s;
                  state_q    <= ST_RESP;
               end else if (tmo_exp_s) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= ST_RESP;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_RESP: begin
               sys_ack_q   <= 1'b1;
               sys_err_q   <= rsp_err_q;
               sys_rdata_q <= rsp_data_q;
               state_q     <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sys_rdata_o = sys_rdata_q;
   assign sys_err_o   = sys_err_q;
   assign sys_ack_o   = sys_ack_q;
   assign slv_addr_o  = slv_addr_q;
   assign slv_wdata_o = slv_wdata_q;
   assign slv_sel_o   = slv_sel_q;
   assign slv_wen_o   = slv_wen_q;
   assign slv_ren_o   = slv_ren_q;

endmodule

// File: tb/tb_sys_bus_router.sv
// Directed self-checking bench for sys_bus_router; honours SYS_BUS_ROUTER_TMO_EN for the silent-slave case.
module tb_sys_bus_router;

   localparam int TMO = 16;

`ifdef SYS_BUS_ROUTER_TMO_EN
   localparam int          T3_K  = TMO + 2;
   localparam logic [31:0] T3_RD = 32'h0000_0000;
   localparam logic        T3_ER = 1'b1;
`else
   localparam int          T3_K  = 22;
   localparam logic [31:0] T3_RD = 32'h0BAD_BEEF;
   localparam logic        T3_ER = 1'b0;
`endif

   logic         sys_clk_i;
   logic         sys_rstn_i;
   logic [31:0]  sys_addr_i;
   logic [31:0]  sys_wdata_i;
   logic [3:0]   sys_sel_i;
   logic         sys_wen_i;
   logic         sys_ren_i;
   logic [31:0]  sys_rdata_o;
   logic         sys_err_o;
   logic         sys_ack_o;
   logic [19:0]  slv_addr_o;
   logic [31:0]  slv_wdata_o;
   logic [3:0]   slv_sel_o;
   logic [7:0]   slv_wen_o;
   logic [7:0]   slv_ren_o;
   logic [255:0] slv_rdata_i;
   logic [7:0]   slv_err_i;
   logic [7:0]   slv_ack_i;

   int n_cmp;
   int n_mis;

   sys_bus_router #(
      .AXI_DW (32), .AXI_AW (32), .AXI_SW (4),
      .SLV_N (8), .SLV_AW (20), .TMO_CYC (TMO)
   ) dut (
      .sys_clk_i (sys_clk_i), .sys_rstn_i (sys_rstn_i),
      .sys_addr_i (sys_addr_i), .sys_wdata_i (sys_wdata_i), .sys_sel_i (sys_sel_i),
      .sys_wen_i (sys_wen_i), .sys_ren_i (sys_ren_i),
      .sys_rdata_o (sys_rdata_o), .sys_err_o (sys_err_o), .sys_ack_o (sys_ack_o),
      .slv_addr_o (slv_addr_o), .slv_wdata_o (slv_wdata_o), .slv_sel_o (slv_sel_o),
      .slv_wen_o (slv_wen_o), .slv_ren_o (slv_ren_o),
      .slv_rdata_i (slv_rdata_i), .slv_err_i (slv_err_i), .slv_ack_i (slv_ack_i)
   );

   initial sys_clk_i = 1'b0;
   always #5 sys_clk_i = ~sys_clk_i;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return {22'd0, sys_ack_o, sys_err_o, sys_rdata_o, slv_wen_o, slv_ren_o,
              slv_addr_o, slv_wdata_o, slv_sel_o};
   endfunction

   // Cycle k = 0 is the slave-strobe cycle; slave acks driven in cycle k are sampled at its closing edge.
   task automatic txn(input string tag, input logic wr, input logic both,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int sl, input int ack_k, input logic [31:0] rd, input logic er,
                      input int spur_k, input logic [7:0] spur_m, input int extra_k,
                      input int exp_k, input logic [31:0] exp_rd, input logic exp_er);
      logic [7:0] oh;
      int         last;
      int         n_ack;
      oh    = 8'd1 << addr[22:20];
      last  = exp_k + 2;
      if (ack_k + 3 > last) last = ack_k + 3;
      n_ack = 0;
      sys_addr_i  = addr;
      sys_wdata_i = wd;
      sys_sel_i   = 4'hA;
      sys_wen_i   = wr;
      sys_ren_i   = !wr || both;
      for (int k = 0; k <= last; k++) begin
         @(negedge sys_clk_i);
         sys_wen_i   = 1'b0;
         sys_ren_i   = 1'b0;
         slv_ack_i   = 8'd0;
         slv_err_i   = 8'd0;
         slv_rdata_i = '0;
         if (k == extra_k) begin
            sys_wen_i  = 1'b1;
            sys_addr_i = 32'h0070_0000;
         end
         if (k == ack_k) begin
            slv_ack_i[sl]             = 1'b1;
            slv_err_i[sl]             = er;
            slv_rdata_i[sl*32 +: 32]  = rd;
         end
         if (k == spur_k) slv_ack_i = slv_ack_i | spur_m;
         if (k == 0) begin
            check_eq({tag, "_wen"},   {120'd0, slv_wen_o}, {120'd0, (wr ? oh : 8'd0)});
            check_eq({tag, "_ren"},   {120'd0, slv_ren_o}, {120'd0, (wr ? 8'd0 : oh)});
            check_eq({tag, "_addr"},  {108'd0, slv_addr_o}, {108'd0, addr[19:0]});
            check_eq({tag, "_wdata"}, {96'd0, slv_wdata_o, slv_sel_o}, {96'd0, wd, 4'hA});
         end
         if (k == 1)
            check_eq({tag, "_strb1"}, {112'd0, slv_wen_o, slv_ren_o}, 128'd0);
         if (extra_k >= 0 && k == extra_k + 1)
            check_eq({tag, "_drop"}, {112'd0, slv_wen_o, slv_ren_o}, 128'd0);
         if (sys_ack_o) n_ack = n_ack + 1;
         if (k == exp_k)
            check_eq({tag, "_rsp"}, {94'd0, sys_ack_o, sys_err_o, sys_rdata_o},
                     {94'd0, 1'b1, exp_er, exp_rd});
         if (k == exp_k + 1)
            check_eq({tag, "_hold"}, {94'd0, sys_ack_o, sys_err_o, sys_rdata_o},
                     {94'd0, 1'b0, 1'b0, exp_rd});
      end
      check_eq({tag, "_nack"}, 128'(n_ack), 128'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack;
      n_cmp = 0;
      n_mis = 0;
      sys_rstn_i  = 1'b0;
      sys_addr_i  = 32'd0;
      sys_wdata_i = 32'd0;
      sys_sel_i   = 4'd0;
      sys_wen_i   = 1'b0;
      sys_ren_i   = 1'b0;
      slv_rdata_i = '0;
      slv_err_i   = 8'd0;
      slv_ack_i   = 8'd0;
      repeat (2) @(negedge sys_clk_i);
      check_eq("rst_init", all_outs(), 128'd0);
      sys_rstn_i = 1'b1;
      @(negedge sys_clk_i);
      check_eq("idle", all_outs(), 128'd0);

      //   tag    wr    both  addr          wdata         sl ack rdata         er    spur sm     ext exp   exp_rd        exp_er
      txn("wr3",  1'b1, 1'b0, 32'h0030_0010, 32'hDEAD_BEEF, 3, 0,  32'h5555_AAAA, 1'b0, -1, 8'h00, -1, 2,    32'h0,        1'b0);
      txn("rd5",  1'b0, 1'b0, 32'h0050_0004, 32'h0,        5, 4,  32'h1234_5678, 1'b0, -1, 8'h00, -1, 6,    32'h1234_5678, 1'b0);
      txn("tmo2", 1'b0, 1'b0, 32'h0020_0000, 32'h0,        2, 20, 32'h0BAD_BEEF, 1'b0, -1, 8'h00, -1, T3_K, T3_RD,        T3_ER);
      txn("err6", 1'b0, 1'b0, 32'h0060_0008, 32'h0,        6, 3,  32'h6666_6666, 1'b1, 1,  8'h02, -1, 5,    32'h6666_6666, 1'b1);
      txn("both", 1'b1, 1'b1, 32'h0040_0020, 32'h0102_0304, 4, 3,  32'h4444_4444, 1'b0, -1, 8'h00, 1,  5,    32'h0,        1'b0);
      txn("alias",1'b0, 1'b0, 32'hFF10_0000, 32'h0,        1, 1,  32'hA5A5_0001, 1'b0, -1, 8'h00, -1, 3,    32'hA5A5_0001, 1'b0);

      // reset during WAIT, then a pending slave-1 ack must not produce a response
      sys_addr_i = 32'h0010_0044;
      sys_sel_i  = 4'h3;
      sys_ren_i  = 1'b1;
      @(negedge sys_clk_i);
      sys_ren_i = 1'b0;
      @(negedge sys_clk_i);
      @(negedge sys_clk_i);
      sys_rstn_i = 1'b0;
      #1;
      check_eq("rst_mid", all_outs(), 128'd0);
      slv_ack_i[1] = 1'b1;
      slv_rdata_i[63:32] = 32'h7777_7777;
      @(negedge sys_clk_i);
      sys_rstn_i = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk_i);
         if (sys_ack_o) n_ack = n_ack + 1;
      end
      check_eq("rst_noack", 128'(n_ack), 128'd0);
      slv_ack_i   = 8'd0;
      slv_rdata_i = '0;
      txn("postrst", 1'b0, 1'b0, 32'h0010_0048, 32'h0, 1, 0, 32'hCAFE_F00D, 1'b0, -1, 8'h00, -1, 2, 32'hCAFE_F00D, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
